// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_pkg                                                    |
// | Description : Shared constants, receiver state encoding and the mode       |
// |               helper for the codec capture path.                           |
// |               AUDIO_WIDTH  - native codec sample width                     |
// |               rx_state_t   - receiver state encoding                       |
// |               MODE_I2S/LJ  - serial alignment selectors                    |
// |               left_level() - LRCK level that marks the left channel        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package audio_pkg;

    localparam int AUDIO_WIDTH = 16;

    // SKIP names the one-bit I2S delay slot.  The receiver absorbs that slot
    // on the very bclk_rise that reveals the LRCK edge, so the slot never
    // needs a state-register cycle of its own.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } rx_state_t;

    localparam bit MODE_I2S = 1'b1;
    localparam bit MODE_LJ  = 1'b0;

    // I2S marks left with LRCK low; left-justified marks left with LRCK high.
    function automatic logic left_level(input bit mode);
        return (mode == MODE_I2S) ? 1'b0 : 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_edge                                                    |
// | Description : Multi-stage synchroniser.  One input (i_edge) also gets a    |
// |               registered rising-edge detector; the i_d bus is only         |
// |               synchronised.                                                |
// |   clk    in  system clock                                                  |
// |   rst_n  in  asynchronous active-low reset                                 |
// |   i_edge in  asynchronous signal to edge-detect                            |
// |   i_d    in  asynchronous bus, plain synchronisation                       |
// |   o_d    out synchronised i_d                                              |
// |   o_rise out one-cycle pulse after a synchronised rise of i_edge           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_edge,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d,
    output logic             o_rise
);

    logic [STAGES-1:0]            r_edge_sync;
    logic                         r_edge_prev;
    logic                         r_rise;
    logic [STAGES-1:0][WIDTH-1:0] r_d_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_sync <= '0;
            r_edge_prev <= 1'b0;
            r_rise      <= 1'b0;
            r_d_sync    <= '0;
        end else begin
            r_edge_sync <= {r_edge_sync[STAGES-2:0], i_edge};
            r_edge_prev <= r_edge_sync[STAGES-1];
            r_rise      <= r_edge_sync[STAGES-1] & ~r_edge_prev;
            r_d_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_d_sync[i] <= r_d_sync[i-1];
            end
        end
    end

    assign o_d    = r_d_sync[STAGES-1];
    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/audio_adc_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_adc_receiver                                           |
// | Description : WM8731 ADC capture.  Deserialises AUD_ADCDAT into stereo     |
// |               frames and presents them on a valid/ready handshake with     |
// |               sticky overrun and a truncation pulse.                       |
// |   Clk           in  system clock                                           |
// |   Reset_n       in  asynchronous active-low reset                          |
// |   AUD_BCLK      in  codec bit clock (asynchronous)                         |
// |   AUD_ADCLRCK   in  codec ADC frame clock (asynchronous)                   |
// |   AUD_ADCDAT    in  codec serial data (asynchronous)                       |
// |   LDATA/RDATA   out left/right sample of the held frame                    |
// |   valid         out a frame is held and not yet consumed                   |
// |   ready         in  consumer takes the frame on valid && ready             |
// |   overrun       out sticky, a completed frame was dropped                  |
// |   clear_overrun in  synchronous clear of overrun                           |
// |   frame_err     out one-cycle pulse when a channel is truncated            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module audio_adc_receiver
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_WIDTH,
    parameter bit I2S_MODE    = MODE_I2S,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] LDATA,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun,
    input  logic                  clear_overrun,
    output logic                  frame_err
);

    localparam int               CNT_W       = $clog2(DATA_WIDTH + 1);
    localparam logic [1:0]       c_ST_IDLE   = 2'(IDLE);
    localparam logic [1:0]       c_ST_SHIFT  = 2'(SHIFT);
    localparam logic [1:0]       c_ST_WAIT   = 2'(WAIT);
    localparam logic             c_LEFT_LVL  = left_level(I2S_MODE);
    localparam logic [CNT_W-1:0] c_LAST_BIT  = CNT_W'(DATA_WIDTH - 1);

    logic                  w_bclk_rise;
    logic [1:0]            w_sync;
    logic                  w_lrck;
    logic                  w_dat;
    logic                  w_lr_edge;
    logic                  w_new_is_left;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] w_start_shift;
    logic [CNT_W-1:0]      w_start_cnt;
    logic                  w_complete;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_left_shadow;
    logic                  r_left_ok;
    logic                  r_chan_right;
    logic                  r_lrck_prev;
    logic                  r_lr_seen;
    logic [DATA_WIDTH-1:0] r_ldata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_frame_err;

    sync_edge #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (2)
    ) u_sync (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .i_edge (AUD_BCLK),
        .i_d    ({AUD_ADCLRCK, AUD_ADCDAT}),
        .o_d    (w_sync),
        .o_rise (w_bclk_rise)
    );

    assign w_lrck = w_sync[1];
    assign w_dat  = w_sync[0];

    // r_lr_seen suppresses a false edge against the reset value of
    // r_lrck_prev, so capture after reset waits for a genuine LRCK transition.
    assign w_lr_edge     = w_bclk_rise && r_lr_seen && (w_lrck != r_lrck_prev);
    assign w_new_is_left = (w_lrck == c_LEFT_LVL);
    assign w_shift_next  = {r_shift[DATA_WIDTH-2:0], w_dat};

    // Channel start: I2S drops the delay-slot bit seen with the LRCK edge;
    // left-justified takes that same bit as the MSB.
    always_comb begin
        w_start_shift = '0;
        w_start_cnt   = '0;
        if (I2S_MODE == MODE_LJ) begin
            w_start_shift = {{(DATA_WIDTH-1){1'b0}}, w_dat};
            w_start_cnt   = CNT_W'(1);
        end
    end

    // Right LSB arriving with a good left half completes the frame; the
    // output registers load in the same cycle from the next-shift value.
    assign w_complete = w_bclk_rise && (r_state == c_ST_SHIFT) && !w_lr_edge &&
                        (r_cnt == c_LAST_BIT) && r_chan_right && r_left_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_left_shadow <= '0;
            r_left_ok     <= 1'b0;
            r_chan_right  <= 1'b0;
            r_lrck_prev   <= 1'b0;
            r_lr_seen     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_bclk_rise) begin
                r_lrck_prev <= w_lrck;
                r_lr_seen   <= 1'b1;
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_lr_edge && w_new_is_left) begin
                            r_chan_right <= 1'b0;
                            r_shift      <= w_start_shift;
                            r_cnt        <= w_start_cnt;
                            r_state      <= c_ST_SHIFT;
                        end
                    end
                    c_ST_SHIFT: begin
                        if (w_lr_edge) begin
                            // Truncated channel: drop it and restart on the
                            // channel LRCK now selects.
                            r_frame_err  <= 1'b1;
                            r_left_ok    <= 1'b0;
                            r_chan_right <= !w_new_is_left;
                            r_shift      <= w_start_shift;
                            r_cnt        <= w_start_cnt;
                        end else begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == c_LAST_BIT) begin
                                r_cnt   <= '0;
                                r_state <= c_ST_WAIT;
                                if (!r_chan_right) begin
                                    r_left_shadow <= w_shift_next;
                                    r_left_ok     <= 1'b1;
                                end else begin
                                    r_left_ok     <= 1'b0;
                                end
                            end
                        end
                    end
                    c_ST_WAIT: begin
                        if (w_lr_edge) begin
                            r_chan_right <= !w_new_is_left;
                            r_shift      <= w_start_shift;
                            r_cnt        <= w_start_cnt;
                            r_state      <= c_ST_SHIFT;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // Output holding register.  A frame completing while the previous one
    // is still held is dropped unless the consumer takes the old one in the
    // same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ldata   <= '0;
            r_rdata   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete && (!r_valid || ready)) begin
                r_ldata <= r_left_shadow;
                r_rdata <= w_shift_next;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (w_complete && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign LDATA     = r_ldata;
    assign RDATA     = r_rdata;
    assign valid     = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_audio_adc_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_audio_adc_receiver                                        |
// | Description : Self-checking bench for audio_adc_receiver.  An I2S DUT and  |
// |               a left-justified DUT share BCLK; directed frames push their  |
// |               expected samples into queues that monitors drain on each     |
// |               handshake.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_audio_adc_receiver;

    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         bclk = 1'b0;
    logic         lrck = 1'b1;
    logic         dat = 1'b0;
    logic         ready = 1'b1;
    logic         clear_overrun = 1'b0;
    logic         lj_lrck = 1'b0;
    logic         lj_dat = 1'b0;
    logic         lj_ready = 1'b1;
    logic         lj_clear = 1'b0;

    logic [W-1:0] ldata, rdata, lj_ldata, lj_rdata;
    logic         valid, overrun, frame_err;
    logic         lj_valid, lj_overrun, lj_frame_err;

    int           total = 0;
    int           bad = 0;
    int           fe_count = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] sb_lj[$];
    logic [2*W-1:0] exp_frame;
    time          t_lsb = 0;
    bit           lat_chk = 1'b0;
    logic         lat_prev = 1'b0;
    bit           sel_lj = 1'b0;

    always #10 Clk = ~Clk;

    audio_adc_receiver #(.DATA_WIDTH(W), .I2S_MODE(1'b1), .SYNC_STAGES(2)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck),
        .AUD_ADCDAT(dat), .LDATA(ldata), .RDATA(rdata), .valid(valid),
        .ready(ready), .overrun(overrun), .clear_overrun(clear_overrun),
        .frame_err(frame_err)
    );

    audio_adc_receiver #(.DATA_WIDTH(W), .I2S_MODE(1'b0), .SYNC_STAGES(2)) u_dut_lj (
        .Clk(Clk), .Reset_n(Reset_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lj_lrck),
        .AUD_ADCDAT(lj_dat), .LDATA(lj_ldata), .RDATA(lj_rdata), .valid(lj_valid),
        .ready(lj_ready), .overrun(lj_overrun), .clear_overrun(lj_clear),
        .frame_err(lj_frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main scoreboard: sampled 5 ns before each rising edge, i.e. the state
    // the DUT sees at that edge.
    always begin
        @(negedge Clk);
        #5;
        if (frame_err === 1'b1) fe_count++;
        if (valid === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL i2s_frame: got L=%h R=%h expected no frame", ldata, rdata);
            end else begin
                exp_frame = sb.pop_front();
                check("i2s_frame", {ldata, rdata}, exp_frame);
            end
        end
    end

    always begin
        @(negedge Clk);
        #5;
        if (lj_valid === 1'b1 && lj_ready === 1'b1) begin
            if (sb_lj.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lj_frame: got L=%h R=%h expected no frame", lj_ldata, lj_rdata);
            end else begin
                check("lj_frame", {lj_ldata, lj_rdata}, sb_lj.pop_front());
            end
        end
    end

    // Latency from the right-LSB BCLK rise to valid (4 Clk, sampled 1 ns late).
    always begin
        @(posedge Clk);
        #1;
        if (lat_chk && valid === 1'b1 && lat_prev === 1'b0) begin
            total++;
            if (($time - t_lsb) > 81) begin
                bad++;
                $display("FAIL latency: got %0d ns expected <= 81 ns", $time - t_lsb);
            end
            lat_chk = 1'b0;
        end
        lat_prev = valid;
    end

    // One BCLK period = 16 Clk: data/LRCK change on the falling edge.
    task automatic send_bit(input logic l, input logic d, input bit mark, input bit rdy_pulse);
        @(negedge Clk);
        bclk = 1'b0;
        if (sel_lj) begin
            lj_lrck = l;
            lj_dat  = d;
        end else begin
            lrck = l;
            dat  = d;
        end
        repeat (8) @(negedge Clk);
        bclk = 1'b1;
        if (mark) t_lsb = $time;
        if (rdy_pulse) begin
            // ready covers exactly the edge where the new frame completes
            repeat (3) @(negedge Clk);
            ready = 1'b1;
            @(negedge Clk);
            ready = 1'b0;
            repeat (3) @(negedge Clk);
        end else begin
            repeat (7) @(negedge Clk);
        end
    endtask

    task automatic send_slot(input logic lvl, input logic [W-1:0] word, input int nbits,
                             input bit i2s, input bit mark, input bit rdy_pulse);
        for (int i = 0; i < nbits; i++) begin
            int   pos;
            logic d;
            pos = i2s ? i - 1 : i;
            d   = (pos >= 0 && pos < W) ? word[W-1-pos] : 1'b0;
            send_bit(lvl, d, mark && (pos == W-1), rdy_pulse && (pos == W-1));
        end
    endtask

    task automatic send_frame(input bit lj, input logic [W-1:0] l, input logic [W-1:0] r,
                              input bit push, input bit rdy_pulse);
        if (lj) begin
            if (push) sb_lj.push_back({l, r});
            sel_lj = 1'b1;
            send_slot(1'b1, l, 32, 1'b0, 1'b0, 1'b0);
            send_slot(1'b0, r, 32, 1'b0, 1'b1, 1'b0);
            sel_lj = 1'b0;
        end else begin
            if (push) sb.push_back({l, r});
            send_slot(1'b0, l, 32, 1'b1, 1'b0, 1'b0);
            send_slot(1'b1, r, 32, 1'b1, 1'b1, rdy_pulse);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge Clk);
        #3;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ldata", {16'd0, ldata}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Basic I2S frame with latency measurement
        repeat (4) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        lat_chk = 1'b1;
        send_frame(1'b0, 16'h8001, 16'h7FFE, 1'b1, 1'b0);
        check("lat_seen", {31'd0, lat_chk}, 32'd0);

        // Left-justified, inverted LRCK polarity
        sel_lj = 1'b1;
        repeat (4) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        sel_lj = 1'b0;
        send_frame(1'b1, 16'h8001, 16'h7FFE, 1'b1, 1'b0);
        check("lj_no_overrun", {31'd0, lj_overrun}, 32'd0);

        // Overrun: three frames with no consumer
        ready = 1'b0;
        send_frame(1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0);
        send_frame(1'b0, 16'h3333, 16'h4444, 1'b0, 1'b0);
        send_frame(1'b0, 16'h5555, 16'h6666, 1'b0, 1'b0);
        check("ovr_ldata", {16'd0, ldata}, 32'h1111);
        check("ovr_rdata", {16'd0, rdata}, 32'h2222);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        @(negedge Clk);
        ready = 1'b1;
        clear_overrun = 1'b1;
        @(negedge Clk);
        clear_overrun = 1'b0;
        @(negedge Clk);
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        check("ovr_drained", {31'd0, valid}, 32'd0);
        send_frame(1'b0, 16'h7777, 16'h8888, 1'b1, 1'b0);
        check("no_frame_err_yet", fe_count, 32'd0);

        // Truncated left channel (10 bits), then a clean frame
        send_slot(1'b0, 16'hFFFF, 10, 1'b1, 1'b0, 1'b0);
        send_slot(1'b1, 16'h5A5A, 32, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 16'hABCD, 16'h1234, 1'b1, 1'b0);
        check("trunc_frame_err", fe_count, 32'd1);

        // Consumer accepts in the exact completion cycle of the next frame
        ready = 1'b0;
        send_frame(1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
        send_frame(1'b0, 16'hC3C3, 16'h3C3C, 1'b1, 1'b1);
        check("same_cyc_valid", {31'd0, valid}, 32'd1);
        check("same_cyc_ldata", {16'd0, ldata}, 32'hC3C3);
        check("same_cyc_rdata", {16'd0, rdata}, 32'h3C3C);
        check("same_cyc_overrun", {31'd0, overrun}, 32'd0);
        @(negedge Clk);
        ready = 1'b1;
        repeat (2) @(negedge Clk);

        // Asynchronous reset in the middle of a right channel
        ready = 1'b0;
        send_frame(1'b0, 16'h1357, 16'h2468, 1'b0, 1'b0);
        send_frame(1'b0, 16'h9999, 16'hAAAA, 1'b0, 1'b0);
        send_slot(1'b0, 16'h4321, 32, 1'b1, 1'b0, 1'b0);
        send_slot(1'b1, 16'hBEEF, 10, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_ldata", {16'd0, ldata}, 32'd0);
        check("arst_rdata", {16'd0, rdata}, 32'd0);
        check("arst_overrun", {31'd0, overrun}, 32'd0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 22; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 16'h2468, 16'h1357, 1'b1, 1'b0);
        repeat (4) @(negedge Clk);

        check("sb_empty", sb.size(), 32'd0);
        check("sb_lj_empty", sb_lj.size(), 32'd0);
        check("final_frame_err", fe_count, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
